// File: rtl/mac16_pkg.sv
// Shared widths, FSM encoding and small arithmetic helpers for the mac16 accumulator.
package mac16_pkg;
  localparam int OPW   = 16;
  localparam int PRODW = 32;
  localparam int ACCW  = 40;
  localparam int CNTW  = 8;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef struct packed {
    logic [PRODW-1:0] s;
    logic [PRODW-1:0] c;
  } csa_t;

  // 3:2 compressor across a whole row; the carry row is pre-shifted into weight position.
  function automatic csa_t csa3(input logic [PRODW-1:0] x, input logic [PRODW-1:0] y,
                                input logic [PRODW-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == {CNTW{1'b1}}) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/wallace16.sv
// Combinational unsigned 16x16 multiplier: carry-save tree 16->11->8->6->4->3->2 rows, then one adder.
module wallace16
  import mac16_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] p
);
  logic [PRODW-1:0] pp [0:15];
  logic [PRODW-1:0] r1 [0:10];
  logic [PRODW-1:0] r2 [0:7];
  logic [PRODW-1:0] r3 [0:5];
  logic [PRODW-1:0] r4 [0:3];
  logic [PRODW-1:0] r5 [0:2];
  logic [PRODW-1:0] r6 [0:1];

  always_comb begin
    for (int i = 0; i < OPW; i++) begin
      pp[i] = b[i] ? (PRODW'(a) << i) : '0;
    end
    {r1[0], r1[1]} = csa3(pp[0],  pp[1],  pp[2]);
    {r1[2], r1[3]} = csa3(pp[3],  pp[4],  pp[5]);
    {r1[4], r1[5]} = csa3(pp[6],  pp[7],  pp[8]);
    {r1[6], r1[7]} = csa3(pp[9],  pp[10], pp[11]);
    {r1[8], r1[9]} = csa3(pp[12], pp[13], pp[14]);
    r1[10] = pp[15];

    {r2[0], r2[1]} = csa3(r1[0], r1[1], r1[2]);
    {r2[2], r2[3]} = csa3(r1[3], r1[4], r1[5]);
    {r2[4], r2[5]} = csa3(r1[6], r1[7], r1[8]);
    r2[6] = r1[9];
    r2[7] = r1[10];

    {r3[0], r3[1]} = csa3(r2[0], r2[1], r2[2]);
    {r3[2], r3[3]} = csa3(r2[3], r2[4], r2[5]);
    r3[4] = r2[6];
    r3[5] = r2[7];

    {r4[0], r4[1]} = csa3(r3[0], r3[1], r3[2]);
    {r4[2], r4[3]} = csa3(r3[3], r3[4], r3[5]);

    {r5[0], r5[1]} = csa3(r4[0], r4[1], r4[2]);
    r5[2] = r4[3];

    {r6[0], r6[1]} = csa3(r5[0], r5[1], r5[2]);
    p = r6[0] + r6[1];
  end
endmodule

// File: rtl/mac16_acc.sv
// Streaming unsigned dot-product engine: operand reg -> product reg -> 40-bit accumulator, one result per in_last.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module mac16_acc
  import mac16_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_sum,
  output logic [CNTW-1:0] out_count,
  output logic            out_ovf,
  output logic [1:0]      dbg_state
);
  logic [1:0]       state;
  logic             op_valid, op_last;
  logic [OPW-1:0]   op_a, op_b;
  logic             pr_valid, pr_last;
  logic [PRODW-1:0] prod, mult;
  logic [ACCW-1:0]  acc;
  logic [CNTW-1:0]  count;
  logic             ovf;
  logic [ACCW:0]    sum_full;
  logic             in_fire, out_fire, fin;

  assign in_ready  = (state == ST_ACC);
  assign dbg_state = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fin       = pr_valid && pr_last;
  assign sum_full  = {1'b0, acc} + {{(ACCW-PRODW+1){1'b0}}, prod};

  wallace16 u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_last  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      pr_valid <= 1'b0;
      pr_last  <= 1'b0;
      prod     <= '0;
    end else begin
      op_valid <= in_fire;
      if (in_fire) begin
        op_a    <= a;
        op_b    <= b;
        op_last <= in_last;
      end
      pr_valid <= op_valid;
      if (op_valid) begin
        prod    <= mult;
        pr_last <= op_last;
      end
    end
  end

  // The final term bypasses acc straight into the result registers so acc restarts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_fire) out_valid <= 1'b0;
      if (pr_valid) begin
        if (pr_last) begin
          out_sum   <= sum_full[ACCW-1:0];
          out_count <= sat_inc(count);
          out_ovf   <= ovf | sum_full[ACCW];
          out_valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
          ovf       <= 1'b0;
        end else begin
          acc   <= sum_full[ACCW-1:0];
          count <= sat_inc(count);
          ovf   <= ovf | sum_full[ACCW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      case (state)
        ST_ACC:   if (in_fire && in_last) state <= ST_FLUSH;
        ST_FLUSH: if (fin) state <= ST_OUT;
        ST_OUT:   if (out_fire) state <= ST_ACC;
        default:  state <= ST_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_mac16_acc.sv
// Directed bench for mac16_acc: inputs driven and outputs sampled 1ns after each rising edge.
module tb_mac16_acc;
  import mac16_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     a, b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [39:0]     out_sum;
  logic [7:0]      out_count;
  logic            out_ovf;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_sum;

  mac16_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic lv);
    int n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    in_last = lv;
    while (!in_ready && n < 100) begin
      cycle();
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    cycle();
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      cycle();
      n++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  // scoreboard: compare the pending result against the head of exp_q
  task automatic check_result(input string tag, input logic [7:0] cnt, input logic ovf);
    logic [39:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hx;
    chk({tag, "_sum"}, out_sum, e);
    chk({tag, "_count"}, out_count, cnt);
    chk({tag, "_ovf"}, out_ovf, ovf);
  endtask

  logic [15:0] va [0:9];
  logic [15:0] vb [0:9];
  logic        seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; in_last = 1'b0; out_ready = 1'b0;

    // reset state
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    cycle();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", dbg_state, ST_ACC);

    // single term 3*4, exact latency
    exp_q.push_back(40'd12);
    send(16'd3, 16'd4, 1'b1);
    idle(0);
    chk("t1_valid_e0", out_valid, 0);
    chk("t1_ready_e0", in_ready, 0);
    cycle();
    chk("t1_valid_e1", out_valid, 0);
    cycle();
    chk("t1_valid_e2", out_valid, 1);
    check_result("t1", 8'd1, 1'b0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t1_valid_after", out_valid, 0);
    chk("t1_ready_after", in_ready, 1);

    // back-to-back terms, 1+4+9+16
    exp_q.push_back(40'd30);
    send(16'd1, 16'd1, 1'b0);
    send(16'd2, 16'd2, 1'b0);
    send(16'd3, 16'd3, 1'b0);
    send(16'd4, 16'd4, 1'b1);
    idle(0);
    chk("t2_ready_e0", in_ready, 0);
    chk("t2_state_flush", dbg_state, ST_FLUSH);
    cycle();
    chk("t2_ready_e1", in_ready, 0);
    cycle();
    chk("t2_valid_e2", out_valid, 1);
    chk("t2_ready_out", in_ready, 0);
    check_result("t2", 8'd4, 1'b0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t2_ready_after", in_ready, 1);

    // 257 x 0xFFFF^2 with out_ready already high: count saturates, ovf set
    out_ready = 1'b1;
    exp_q.push_back(40'h00FDFE0101);
    for (int i = 0; i < 257; i++) send(16'hFFFF, 16'hFFFF, (i == 256));
    idle(0);
    wait_out(10);
    check_result("t3", 8'd255, 1'b1);
    cycle();
    chk("t3_valid_drop", out_valid, 0);
    chk("t3_ready_after", in_ready, 1);
    out_ready = 1'b0;

    // held result: stable, inputs ignored; fresh ovf after overflow run
    exp_q.push_back(40'd86);
    send(16'd5, 16'd6, 1'b0);
    send(16'd7, 16'd8, 1'b1);
    idle(0);
    wait_out(10);
    check_result("t4", 8'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom_range(1, 65535));
      b = 16'($urandom_range(1, 65535));
      in_last = 1'b1;
      cycle();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_sum", out_sum, 40'd86);
      chk("t4_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t4_one_xfer", out_valid, 0);
    chk("t4_state_acc", dbg_state, ST_ACC);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (out_valid) seen = 1'b1;
    end
    chk("t4_no_ghost", seen, 0);

    // 10 terms with random bubbles
    exp_sum = '0;
    for (int i = 0; i < 10; i++) begin
      va[i] = 16'(1000 * i + 17);
      vb[i] = 16'(65535 - 3000 * i);
      exp_sum = exp_sum + 40'(va[i]) * 40'(vb[i]);
    end
    exp_q.push_back(exp_sum);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 3));
      send(va[i], vb[i], (i == 9));
    end
    idle(0);
    wait_out(10);
    check_result("t5", 8'd10, 1'b0);
    cycle();
    out_ready = 1'b0;

    // reset while in FLUSH discards the pending result
    send(16'd9, 16'd9, 1'b0);
    send(16'd10, 16'd10, 1'b1);
    idle(0);
    chk("t6_state_flush", dbg_state, ST_FLUSH);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", dbg_state, ST_ACC);
    cycle();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (out_valid) seen = 1'b1;
    end
    chk("t6_no_valid", seen, 0);
    exp_q.push_back(40'd35);
    send(16'd5, 16'd7, 1'b1);
    idle(0);
    wait_out(10);
    check_result("t6", 8'd1, 1'b0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t6_end_ready", in_ready, 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
